// File: rtl/key_pkg.sv
// key_pkg: shared FSM state type, parameter defaults and helpers for the
// keypad matrix scanner (key_matrix_scan and scan_tick_gen).
package key_pkg;

   typedef enum logic [1:0] {
      StScan,
      StPressDeb,
      StHeld,
      StRelDeb
   } key_state_e;

   localparam int unsigned DefClkDiv      = 50000;
   localparam int unsigned DefDebTicks    = 4;
   localparam int unsigned DefRepeatTicks = 64;
   localparam logic [3:0]  DefClrCode     = 4'hC;

   // Code shown on bcds when no key has been accepted since reset.
   localparam logic [3:0]  BlankCode      = 4'hF;
   // First column driven after reset (column 0, active-low).
   localparam logic [3:0]  ColFirst       = 4'b1110;

   // Index of the lowest-numbered low bit of an active-low vector.
   // Returns 0 when no bit is low; callers only use it when one is.
   function automatic logic [1:0] first_low(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!v[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: prescaler producing a one-clk tick every CLK_DIV clocks.
module scan_tick_gen
   import key_pkg::*;
#(
   parameter int unsigned CLK_DIV = DefClkDiv
) (
   input  logic rst,
   input  logic clk,
   output logic tick
);

   localparam int unsigned     CntW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

   logic [CntW-1:0] cnt;

   // Free-running divider; tick is registered so it is exactly one clk wide.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (cnt == CntLast) begin
         cnt  <= '0;
         tick <= 1'b1;
      end else begin
         cnt  <= cnt + CntW'(1);
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/key_matrix_scan.sv
// key_matrix_scan: 4x4 keypad scanner with press/release debounce.
// Drives one column low at a time, debounces the first key seen and reports
// it on bcds with an active-low strobe nkpls held for the duration of the press.
// Optional build macro KEY_REPEAT_EN adds auto-repeat of the strobe while held.
module key_matrix_scan
   import key_pkg::*;
#(
   parameter int unsigned CLK_DIV      = DefClkDiv,
   parameter int unsigned DEB_TICKS    = DefDebTicks,
   parameter logic [3:0]  CLR_CODE     = DefClrCode,
   parameter int unsigned REPEAT_TICKS = DefRepeatTicks
) (
   input  logic       rst,
   input  logic       clk,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] bcds,
   output logic       nkpls,
   output logic       koff,
   output logic       clr
);

   // Debounce counter value on the tick that completes DEB_TICKS stable ticks.
   localparam logic [3:0] DebLast = 4'(DEB_TICKS - 1);

   logic       tick;
   logic [3:0] row_meta;
   logic [3:0] row_sync;
   key_state_e state;
   logic [1:0] row_idx;
   logic [1:0] col_idx;
   logic [3:0] deb_cnt;
   logic [3:0] code;
   logic       row_hit;

   assign code    = {row_idx, col_idx};
   // Latched row still reads the key as pressed.
   assign row_hit = ~row_sync[row_idx];

`ifdef KEY_REPEAT_EN
   localparam int unsigned     RepW    = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
   localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_TICKS - 1);

   logic [RepW-1:0] rep_cnt;
   logic            rep_hi;
`else
   logic unused_repeat_ticks;
   assign unused_repeat_ticks = ^REPEAT_TICKS;
`endif

   scan_tick_gen #(
      .CLK_DIV(CLK_DIV)
   ) u_tick (
      .rst (rst),
      .clk (clk),
      .tick(tick)
   );

   // Two-flop synchronizer; resets high so an idle keypad reads as no key.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_meta <= 4'hF;
         row_sync <= 4'hF;
      end else begin
         row_meta <= row;
         row_sync <= row_meta;
      end
   end

   // Scan/debounce FSM with registered outputs; advances only on ticks.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= StScan;
         col     <= ColFirst;
         row_idx <= 2'd0;
         col_idx <= 2'd0;
         deb_cnt <= 4'd0;
         bcds    <= BlankCode;
         nkpls   <= 1'b1;
         koff    <= 1'b1;
         clr     <= 1'b0;
`ifdef KEY_REPEAT_EN
         rep_cnt <= '0;
         rep_hi  <= 1'b0;
`endif
      end else begin
         clr <= 1'b0;
         if (tick) begin
            unique case (state)
               StScan: begin
                  if (row_sync != 4'hF) begin
                     // Lowest low row wins; column is frozen on the key.
                     row_idx <= first_low(row_sync);
                     col_idx <= first_low(col);
                     deb_cnt <= 4'd0;
                     state   <= StPressDeb;
                  end else begin
                     col <= {col[2:0], col[3]};
                  end
               end
               StPressDeb: begin
                  if (!row_hit) begin
                     state <= StScan;
                  end else if (deb_cnt == DebLast) begin
                     bcds  <= code;
                     koff  <= 1'b0;
                     nkpls <= 1'b0;
                     clr   <= (code == CLR_CODE);
                     state <= StHeld;
`ifdef KEY_REPEAT_EN
                     rep_cnt <= '0;
                     rep_hi  <= 1'b0;
`endif
                  end else begin
                     deb_cnt <= deb_cnt + 4'd1;
                  end
               end
               StHeld: begin
                  if (!row_hit) begin
                     deb_cnt <= 4'd0;
                     state   <= StRelDeb;
                  end
`ifdef KEY_REPEAT_EN
                  // Repeat strobe: nkpls high for one tick every REPEAT_TICKS ticks.
                  else if (rep_hi) begin
                     nkpls   <= 1'b0;
                     rep_hi  <= 1'b0;
                     clr     <= (code == CLR_CODE);
                     rep_cnt <= rep_cnt + RepW'(1);
                  end else if (rep_cnt == RepLast) begin
                     nkpls   <= 1'b1;
                     rep_hi  <= 1'b1;
                     rep_cnt <= '0;
                  end else begin
                     rep_cnt <= rep_cnt + RepW'(1);
                  end
`endif
               end
               StRelDeb: begin
                  if (row_hit) begin
                     state <= StHeld;
                  end else if (deb_cnt == DebLast) begin
                     // bcds keeps the last code; rotation resumes next tick.
                     nkpls <= 1'b1;
                     koff  <= 1'b1;
                     state <= StScan;
                  end else begin
                     deb_cnt <= deb_cnt + 4'd1;
                  end
               end
               default: state <= StScan;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_key_matrix_scan.sv
// tb_key_matrix_scan: directed scoreboard bench for key_matrix_scan.
// Stimulus pushes expected nkpls edges into a queue; the monitor pops and
// compares on every nkpls edge it sees. Build with KEY_REPEAT_EN to add the
// auto-repeat scenario.
module tb_key_matrix_scan;

   localparam int unsigned ClkDiv   = 4;
   localparam int unsigned DebTicks = 2;
   localparam int unsigned RepTicks = 8;

   typedef struct {
      logic       fall;
      logic [3:0] bcds;
      logic       koff;
      logic       clr;
      int         gap;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  bcds;
   logic        nkpls;
   logic        koff;
   logic        clr;
   logic [15:0] key_down;

   exp_t exp_q[$];
   int   total    = 0;
   int   bad      = 0;
   int   clr_cnt  = 0;
   int   cyc      = 0;
   int   rise_cyc = 0;
   logic prev_nkpls = 1'b1;

   key_matrix_scan #(
      .CLK_DIV     (ClkDiv),
      .DEB_TICKS   (DebTicks),
      .CLR_CODE    (4'hC),
      .REPEAT_TICKS(RepTicks)
   ) dut (
      .rst  (rst),
      .clk  (clk),
      .row  (row),
      .col  (col),
      .bcds (bcds),
      .nkpls(nkpls),
      .koff (koff),
      .clr  (clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Passive keypad: a held key pulls its row low while its column is driven.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (key_down[r*4+c] && !col[c]) row[r] = 1'b0;
         end
      end
   end

   // Monitor: every nkpls edge must match the next queued expectation.
   always @(negedge clk) begin : mon
      exp_t e;
      cyc++;
      if (clr === 1'b1) clr_cnt++;
      if (nkpls !== prev_nkpls) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL edge_unexpected: got nkpls=%b bcds=%h koff=%b, required no edge",
                     nkpls, bcds, koff);
         end else begin
            e = exp_q.pop_front();
            if (nkpls !== !e.fall || bcds !== e.bcds || koff !== e.koff || clr !== e.clr) begin
               bad++;
               $display("FAIL edge_%s: got nkpls=%b bcds=%h koff=%b clr=%b, required nkpls=%b bcds=%h koff=%b clr=%b",
                        e.fall ? "fall" : "rise", nkpls, bcds, koff, clr,
                        !e.fall, e.bcds, e.koff, e.clr);
            end
            if (e.gap != 0) begin
               total++;
               if (cyc - rise_cyc != e.gap) begin
                  bad++;
                  $display("FAIL repeat_gap: got %0d clk high, required %0d", cyc - rise_cyc, e.gap);
               end
            end
         end
         if (nkpls === 1'b1) rise_cyc = cyc;
         prev_nkpls = nkpls;
      end
   end

   task automatic check(input string name, input logic [3:0] got, input logic [3:0] req);
      total++;
      if (got !== req) begin
         bad++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   task automatic push(input logic fall, input logic [3:0] b, input logic k, input logic c,
                       input int gap);
      exp_q.push_back('{fall, b, k, c, gap});
   endtask

   task automatic wait_ticks(input int n);
      repeat (n * ClkDiv) @(negedge clk);
   endtask

   // Return just after the tick on which column c becomes the driven column.
   task automatic align_col(input int c);
      int n = 0;
      while (col[c] !== 1'b1 && n < 64) begin @(negedge clk); n++; end
      while (col[c] !== 1'b0 && n < 64) begin @(negedge clk); n++; end
      total++;
      if (n >= 64) begin
         bad++;
         $display("FAIL col_scan: got col=%b, required column %0d driven within 64 clk", col, c);
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no finish by 200000 ns, required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      rst      = 1'b0;
      key_down = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst_col", col, 4'b1110);
      check("rst_bcds", bcds, 4'hF);
      check("rst_nkpls", {3'b0, nkpls}, 4'h1);
      check("rst_koff", {3'b0, koff}, 4'h1);
      check("rst_clr", {3'b0, clr}, 4'h0);
      rst = 1'b1;
      wait_ticks(2);

      // Key row1/col2 held 10 ticks, then released.
      push(1'b1, 4'h6, 1'b0, 1'b0, 0);
      push(1'b0, 4'h6, 1'b1, 1'b0, 0);
      align_col(2);
      key_down[6] = 1'b1;
      wait_ticks(10);
      key_down[6] = 1'b0;
      wait_ticks(1);
      check("release_hold", {3'b0, nkpls}, 4'h0);
      wait_ticks(3);
      check("release_nkpls", {3'b0, nkpls}, 4'h1);
      check("release_koff", {3'b0, koff}, 4'h1);
      check("release_bcds", bcds, 4'h6);
      wait_ticks(2);

      // Clear key row3/col0: clr coincides with the fall.
      push(1'b1, 4'hC, 1'b0, 1'b1, 0);
      push(1'b0, 4'hC, 1'b1, 1'b0, 0);
      align_col(0);
      key_down[12] = 1'b1;
      wait_ticks(6);
      key_down[12] = 1'b0;
      wait_ticks(5);

      // Bounce on row0/col0: 1 tick low, 1 high, then 5 low.
      push(1'b1, 4'h0, 1'b0, 1'b0, 0);
      push(1'b0, 4'h0, 1'b1, 1'b0, 0);
      align_col(0);
      key_down[0] = 1'b1;
      wait_ticks(1);
      key_down[0] = 1'b0;
      wait_ticks(1);
      check("bounce_no_strobe", {3'b0, nkpls}, 4'h1);
      key_down[0] = 1'b1;
      wait_ticks(5);
      key_down[0] = 1'b0;
      wait_ticks(5);

      // Rows 1 and 2 on col3 together, then a second key while held.
      push(1'b1, 4'h7, 1'b0, 1'b0, 0);
      push(1'b0, 4'h7, 1'b1, 1'b0, 0);
      align_col(3);
      key_down[7]  = 1'b1;
      key_down[11] = 1'b1;
      wait_ticks(5);
      key_down[3] = 1'b1;
      wait_ticks(3);
      key_down = '0;
      wait_ticks(5);

      // Reset during HELD, key kept down through and after reset.
      push(1'b1, 4'h9, 1'b0, 1'b0, 0);
      align_col(1);
      key_down[9] = 1'b1;
      wait_ticks(4);
      push(1'b0, 4'hF, 1'b1, 1'b0, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("midrst_col", col, 4'b1110);
      check("midrst_bcds", bcds, 4'hF);
      check("midrst_nkpls", {3'b0, nkpls}, 4'h1);
      check("midrst_koff", {3'b0, koff}, 4'h1);
      check("midrst_clr", {3'b0, clr}, 4'h0);
      @(negedge clk);
      @(negedge clk);
      push(1'b1, 4'h9, 1'b0, 1'b0, 0);
      push(1'b0, 4'h9, 1'b1, 1'b0, 0);
      rst = 1'b1;
      wait_ticks(10);
      key_down = '0;
      wait_ticks(5);

`ifdef KEY_REPEAT_EN
      // Key 5 held 30 ticks: initial fall plus three one-tick repeat gaps.
      push(1'b1, 4'h5, 1'b0, 1'b0, 0);
      for (int i = 0; i < 3; i++) begin
         push(1'b0, 4'h5, 1'b0, 1'b0, 0);
         push(1'b1, 4'h5, 1'b0, 1'b0, ClkDiv);
      end
      push(1'b0, 4'h5, 1'b1, 1'b0, 0);
      align_col(1);
      key_down[5] = 1'b1;
      wait_ticks(30);
      key_down[5] = 1'b0;
      wait_ticks(5);
`endif

      wait_ticks(2);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL queue_drained: got %0d edges outstanding, required 0", exp_q.size());
      end
      total++;
      if (clr_cnt != 1) begin
         bad++;
         $display("FAIL clr_cycles: got %0d clk with clr high, required 1", clr_cnt);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
